// File: rtl/ddr_init_checker_if.sv
// AXI4 master/slave bundle used between the DDR init checker and the DDR controller.
interface ddr_init_checker_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 128
);
  // Write address channel
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  // Write data channel
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  // Write response channel
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  // Read address channel
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  // Read data channel
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/ddr_init_checker.sv
// Post-init DDR self-check: writes NUM_WORDS single-beat words, reads them back and
// compares, then reports pass/fail. Owns the AXI master port for the whole test.
module ddr_init_checker #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 128,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned           NUM_WORDS  = 16,
  parameter int unsigned           TIMEOUT    = 4096
) (
  input  logic               clk,
  input  logic               ddr_rstn_i,
  input  logic               ddr_init_done,
  ddr_init_checker_if.master axi,
  output logic               ddr_ready,
  output logic               ddr_test_done,
  output logic               ddr_test_fail,
  output logic [1:0]         err_code
);

  localparam int unsigned Lanes = DATA_WIDTH / 32;
  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrData = 2'b01;
  localparam logic [1:0] ErrResp = 2'b10;
  localparam logic [1:0] ErrTmo  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrResp,
    StRdAddr,
    StRdData,
    StPass,
    StFail
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       idx_q, idx_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              init_q;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [1:0]        err_q, err_d;

  logic [31:0]           lane;
  logic [DATA_WIDTH-1:0] pattern;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic                  last_word;
  logic                  tmo_hit;
  logic                  aw_hs, w_hs;
  logic                  unused;

  // Address and data are pure functions of the word index, so they stay stable while valid.
  assign lane      = 32'hA5C3_0000 | {16'h0000, idx_q};
  assign pattern   = {Lanes{lane}};
  assign word_addr = BASE_ADDR + (ADDR_WIDTH'(idx_q) * ADDR_WIDTH'(Bytes));
  assign last_word = (idx_q == 16'(NUM_WORDS - 1));
  // The cycle that would bring the count to TIMEOUT is the last one allowed.
  assign tmo_hit   = (tmo_q == TmoW'(TIMEOUT - 1));

  assign axi.awaddr  = word_addr;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'($clog2(Bytes));
  assign axi.awburst = 2'b01;
  assign axi.awvalid = (state_q == StWrAddr) && !aw_done_q;
  assign axi.wdata   = pattern;
  assign axi.wstrb   = '1;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = (state_q == StWrAddr) && !w_done_q;
  assign axi.bready  = (state_q == StWrResp);
  assign axi.araddr  = word_addr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'($clog2(Bytes));
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state_q == StRdAddr);
  assign axi.rready  = (state_q == StRdData);

  assign aw_hs = axi.awvalid && axi.awready;
  assign w_hs  = axi.wvalid && axi.wready;

  assign ddr_ready     = ready_q;
  assign ddr_test_done = done_q;
  assign ddr_test_fail = fail_q;
  assign err_code      = err_q;

  // Only the error bit of the response codes matters (OKAY/EXOKAY both pass).
  assign unused = ^{axi.bresp[0], axi.rresp[0]};

  // Single-stage capture of the sequencer's done flag.
  always_ff @(posedge clk or negedge ddr_rstn_i) begin
    if (!ddr_rstn_i) init_q <= 1'b0;
    else             init_q <= ddr_init_done;
  end

  // Next-state, index, handshake tracking, timeout and status logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;

    unique case (state_q)
      StIdle: begin
        if (init_q) begin
          state_d = StWrAddr;
          idx_d   = '0;
        end
      end
      StWrAddr: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = StWrResp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (tmo_hit) begin
          state_d = StFail;
          err_d   = ErrTmo;
        end
      end
      StWrResp: begin
        if (axi.bvalid) begin
          if (axi.bresp[1]) begin
            state_d = StFail;
            err_d   = ErrResp;
          end else if (last_word) begin
            state_d = StRdAddr;
            idx_d   = '0;
          end else begin
            state_d = StWrAddr;
            idx_d   = idx_q + 16'd1;
          end
        end else if (tmo_hit) begin
          state_d = StFail;
          err_d   = ErrTmo;
        end
      end
      StRdAddr: begin
        if (axi.arready) begin
          state_d = StRdData;
        end else if (tmo_hit) begin
          state_d = StFail;
          err_d   = ErrTmo;
        end
      end
      StRdData: begin
        if (axi.rvalid) begin
          if (axi.rresp[1]) begin
            state_d = StFail;
            err_d   = ErrResp;
          end else if (axi.rdata != pattern) begin
            state_d = StFail;
            err_d   = ErrData;
          end else if (last_word) begin
            state_d = StPass;
            err_d   = ErrNone;
          end else begin
            state_d = StRdAddr;
            idx_d   = idx_q + 16'd1;
          end
        end else if (tmo_hit) begin
          state_d = StFail;
          err_d   = ErrTmo;
        end
      end
      StPass, StFail: ;
      default: state_d = StIdle;
    endcase

    // Timer restarts on every state entry, including re-entry of the same handshake state.
    if (state_d != state_q) begin
      tmo_d = '0;
    end else if (state_q inside {StWrAddr, StWrResp, StRdAddr, StRdData}) begin
      tmo_d = tmo_q + TmoW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    // Status is sticky; the terminal states are only left through reset.
    ready_d = ready_q || (state_d == StPass);
    done_d  = done_q || (state_d == StPass) || (state_d == StFail);
    fail_d  = fail_q || (state_d == StFail);
  end

  // State and status registers.
  always_ff @(posedge clk or negedge ddr_rstn_i) begin
    if (!ddr_rstn_i) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      tmo_q     <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      err_q     <= ErrNone;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      fail_q    <= fail_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_ddr_init_checker.sv
// Directed bench for ddr_init_checker with a small configurable AXI slave model.
module tb_ddr_init_checker;

  logic         clk;
  logic         ddr_rstn_i;
  logic         ddr_init_done;
  logic         ddr_ready;
  logic         ddr_test_done;
  logic         ddr_test_fail;
  logic [1:0]   err_code;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Slave model knobs
  int aw_delay, w_delay, ar_delay;
  int corrupt_word, bresp_err_word, rresp_err_word;

  ddr_init_checker_if #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) bus ();

  ddr_init_checker #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(128),
    .BASE_ADDR (32'h0),
    .NUM_WORDS (4),
    .TIMEOUT   (16)
  ) dut (
    .clk          (clk),
    .ddr_rstn_i   (ddr_rstn_i),
    .ddr_init_done(ddr_init_done),
    .axi          (bus),
    .ddr_ready    (ddr_ready),
    .ddr_test_done(ddr_test_done),
    .ddr_test_fail(ddr_test_fail),
    .err_code     (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- slave model ----------------
  int           aw_wait, w_wait, ar_wait;
  logic         aw_got, w_got;
  logic         bvalid_q, rvalid_q;
  logic [1:0]   bresp_q, rresp_q;
  logic [127:0] rdata_q;
  logic [127:0] mem [16];
  logic [31:0]  aw_log [16];
  logic [127:0] w_log [16];
  int           aw_cnt, w_cnt, ar_cnt, stab_err;
  logic         w_drop_seen;
  logic         aw_pend, w_pend;
  logic [31:0]  aw_hold;
  logic [127:0] w_hold;

  assign bus.awready = bus.awvalid && (aw_wait >= aw_delay);
  assign bus.wready  = bus.wvalid && (w_wait >= w_delay);
  assign bus.arready = bus.arvalid && (ar_wait >= ar_delay);
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  always @(posedge clk or negedge ddr_rstn_i) begin
    if (!ddr_rstn_i) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bvalid_q <= 1'b0; rvalid_q <= 1'b0;
      bresp_q <= 2'b00; rresp_q <= 2'b00; rdata_q <= '0;
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; stab_err <= 0;
      w_drop_seen <= 1'b0; aw_pend <= 1'b0; w_pend <= 1'b0;
      aw_hold <= '0; w_hold <= '0;
    end else begin
      aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
      ar_wait <= (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;

      // A pending valid must persist with unchanged payload.
      if (aw_pend && (!bus.awvalid || bus.awaddr != aw_hold)) stab_err <= stab_err + 1;
      if (w_pend && (!bus.wvalid || bus.wdata != w_hold)) stab_err <= stab_err + 1;
      aw_pend <= bus.awvalid && !bus.awready;
      w_pend  <= bus.wvalid && !bus.wready;
      aw_hold <= bus.awaddr;
      w_hold  <= bus.wdata;
      if (bus.awvalid && !bus.wvalid) w_drop_seen <= 1'b1;

      if (bus.awvalid && bus.awready) begin
        aw_got <= 1'b1;
        if (aw_cnt < 16) aw_log[aw_cnt] <= bus.awaddr;
        aw_cnt <= aw_cnt + 1;
      end
      if (bus.wvalid && bus.wready) begin
        w_got <= 1'b1;
        if (w_cnt < 16) w_log[w_cnt] <= bus.wdata;
        w_cnt <= w_cnt + 1;
        mem[bus.awaddr[7:4]] <= bus.wdata;
      end
      if ((aw_got || (bus.awvalid && bus.awready)) && (w_got || (bus.wvalid && bus.wready))
          && !bvalid_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= (int'(bus.awaddr[7:4]) == bresp_err_word) ? 2'b10 : 2'b00;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else if (bvalid_q && bus.bready) begin
        bvalid_q <= 1'b0;
      end

      if (bus.arvalid && bus.arready) begin
        ar_cnt   <= ar_cnt + 1;
        rvalid_q <= 1'b1;
        rdata_q  <= mem[bus.araddr[7:4]] ^
                    ((int'(bus.araddr[7:4]) == corrupt_word) ? {4{32'h0000_0100}} : 128'h0);
        rresp_q  <= (int'(bus.araddr[7:4]) == rresp_err_word) ? 2'b11 : 2'b00;
      end else if (rvalid_q && bus.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic apply_reset();
    ddr_rstn_i     = 1'b0;
    ddr_init_done  = 1'b0;
    aw_delay       = 0;
    w_delay        = 0;
    ar_delay       = 0;
    corrupt_word   = -1;
    bresp_err_word = -1;
    rresp_err_word = -1;
    repeat (3) @(negedge clk);
    ddr_rstn_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!ddr_test_done && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (ddr_test_done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: ddr_test_done=%0b after %0d cycles, required 1", name, ddr_test_done,
               budget);
    end
  endtask

  task automatic wait_arvalid(input int budget, input string name, output int start);
    int n = 0;
    while (!bus.arvalid && n < budget) begin
      @(negedge clk);
      n++;
    end
    start = cyc;
    n_checks++;
    if (bus.arvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: arvalid=%0b after %0d cycles, required 1", name, bus.arvalid, budget);
    end
  endtask

  task automatic check_status(input string name, input logic rdy, input logic fl,
                              input logic [1:0] code);
    n_checks++;
    if ({ddr_ready, ddr_test_done, ddr_test_fail, err_code} !== {rdy, 1'b1, fl, code}) begin
      n_fail++;
      $display("FAIL %s: ready/done/fail/err=%0b/%0b/%0b/%b, required %0b/1/%0b/%b", name,
               ddr_ready, ddr_test_done, ddr_test_fail, err_code, rdy, fl, code);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ddr_rstn_i    = 1'b0;
    ddr_init_done = 1'b0;
    #1;
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_valids: aw/w/b/ar/r=%b, required 00000",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
    end
    n_checks++;
    if ({ddr_ready, ddr_test_done, ddr_test_fail, err_code} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_status: ready/done/fail/err=%b, required 00000",
               {ddr_ready, ddr_test_done, ddr_test_fail, err_code});
    end
    n_checks++;
    if (bus.awaddr !== 32'h0 || bus.araddr !== 32'h0 || bus.wdata !== {4{32'hA5C3_0000}}) begin
      n_fail++;
      $display("FAIL reset_payload: awaddr=%h araddr=%h wdata=%h, required 0/0/%h",
               bus.awaddr, bus.araddr, bus.wdata, {4{32'hA5C3_0000}});
    end
    apply_reset();
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.awvalid !== 1'b0 || ddr_test_done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_without_init: awvalid=%0b done=%0b, required 0/0", bus.awvalid,
               ddr_test_done);
    end
  endtask

  task automatic test_zero_wait_pass();
    logic [127:0] exp_d;
    apply_reset();
    repeat (10) @(negedge clk);
    ddr_init_done = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.awvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_latency_1: awvalid=%0b one cycle after init_done, required 0",
               bus.awvalid);
    end
    @(negedge clk);
    n_checks++;
    if (bus.awvalid !== 1'b1 || bus.wvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency_2: awvalid=%0b wvalid=%0b two cycles after, required 1/1",
               bus.awvalid, bus.wvalid);
    end
    wait_done(200, "zero_wait_done");
    check_status("zero_wait_status", 1'b1, 1'b0, 2'b00);
    for (int i = 0; i < 4; i++) begin
      exp_d = {4{32'hA5C3_0000 + 32'(i)}};
      n_checks++;
      if (aw_log[i] !== 32'(i * 16) || w_log[i] !== exp_d) begin
        n_fail++;
        $display("FAIL write_word_%0d: addr=%h data=%h, required %h/%h", i, aw_log[i], w_log[i],
                 32'(i * 16), exp_d);
      end
    end
    n_checks++;
    if (aw_cnt !== 4 || w_cnt !== 4 || ar_cnt !== 4) begin
      n_fail++;
      $display("FAIL zero_wait_counts: aw=%0d w=%0d ar=%0d, required 4/4/4", aw_cnt, w_cnt,
               ar_cnt);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0
        || ddr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_terminal: valids/readies=%b ready=%0b, required 00000/1",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, ddr_ready);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    aw_delay = 3;
    w_delay  = 1;
    ddr_init_done = 1'b1;
    wait_done(400, "backpressure_done");
    check_status("backpressure_status", 1'b1, 1'b0, 2'b00);
    n_checks++;
    if (w_drop_seen !== 1'b1 || stab_err !== 0 || aw_cnt !== 4) begin
      n_fail++;
      $display("FAIL backpressure_channels: w_drop=%0b stab_err=%0d aw=%0d, required 1/0/4",
               w_drop_seen, stab_err, aw_cnt);
    end
  endtask

  task automatic test_data_mismatch();
    apply_reset();
    corrupt_word = 2;
    ddr_init_done = 1'b1;
    wait_done(200, "mismatch_done");
    check_status("mismatch_status", 1'b0, 1'b1, 2'b01);
    repeat (10) @(negedge clk);
    n_checks++;
    if (ar_cnt !== 3 || bus.arvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL mismatch_no_more_ar: ar=%0d arvalid=%0b, required 3/0", ar_cnt,
               bus.arvalid);
    end
  endtask

  task automatic test_error_response();
    apply_reset();
    bresp_err_word = 1;
    ddr_init_done = 1'b1;
    wait_done(200, "bresp_done");
    check_status("bresp_status", 1'b0, 1'b1, 2'b10);
    n_checks++;
    if (aw_cnt !== 2 || ar_cnt !== 0) begin
      n_fail++;
      $display("FAIL bresp_no_read: aw=%0d ar=%0d, required 2/0", aw_cnt, ar_cnt);
    end
    apply_reset();
    rresp_err_word = 0;
    ddr_init_done = 1'b1;
    wait_done(200, "rresp_done");
    check_status("rresp_status", 1'b0, 1'b1, 2'b10);
    n_checks++;
    if (ar_cnt !== 1) begin
      n_fail++;
      $display("FAIL rresp_ar_count: ar=%0d, required 1", ar_cnt);
    end
  endtask

  task automatic test_timeout();
    int start;
    apply_reset();
    ar_delay = 1000;
    ddr_init_done = 1'b1;
    wait_arvalid(200, "timeout_reach_rd", start);
    wait_done(100, "timeout_done");
    check_status("timeout_status", 1'b0, 1'b1, 2'b11);
    n_checks++;
    if (cyc - start !== 16) begin
      n_fail++;
      $display("FAIL timeout_latency: fail seen %0d cycles after RD_ADDR entry, required 16",
               cyc - start);
    end
    // arready on the 16th cycle of RD_ADDR beats the timeout.
    apply_reset();
    ar_delay = 15;
    ddr_init_done = 1'b1;
    wait_done(500, "timeout_edge_done");
    check_status("timeout_edge_status", 1'b1, 1'b0, 2'b00);
    n_checks++;
    if (ar_cnt !== 4) begin
      n_fail++;
      $display("FAIL timeout_edge_reads: ar=%0d, required 4", ar_cnt);
    end
  endtask

  task automatic test_reset_mid_test();
    int start;
    apply_reset();
    ddr_init_done = 1'b1;
    wait_arvalid(200, "midreset_reach_rd", start);
    #2;
    ddr_rstn_i = 1'b0;
    #1;
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, ddr_ready,
         ddr_test_done, ddr_test_fail, err_code} !== 10'b0) begin
      n_fail++;
      $display("FAIL midreset_async: outputs=%b, required all 0",
               {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready, ddr_ready,
                ddr_test_done, ddr_test_fail, err_code});
    end
    ddr_init_done = 1'b0;
    repeat (2) @(negedge clk);
    ddr_rstn_i = 1'b1;
    repeat (3) @(negedge clk);
    ddr_init_done = 1'b1;
    wait_done(200, "midreset_rerun_done");
    check_status("midreset_rerun_status", 1'b1, 1'b0, 2'b00);
    n_checks++;
    if (aw_cnt !== 4 || aw_log[0] !== 32'h0 || ar_cnt !== 4) begin
      n_fail++;
      $display("FAIL midreset_rerun_from_0: aw=%0d first_addr=%h ar=%0d, required 4/0/4",
               aw_cnt, aw_log[0], ar_cnt);
    end
  endtask

  initial begin
    ddr_rstn_i     = 1'b0;
    ddr_init_done  = 1'b0;
    aw_delay       = 0;
    w_delay        = 0;
    ar_delay       = 0;
    corrupt_word   = -1;
    bresp_err_word = -1;
    rresp_err_word = -1;
    test_reset();
    test_zero_wait_pass();
    test_backpressure();
    test_data_mismatch();
    test_error_response();
    test_timeout();
    test_reset_mid_test();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
